// File: rtl/rr_mux_4_1_if.sv
// rr_mux_4_1_if: four valid/ready producer channels plus one registered output stream
interface rr_mux_4_1_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       in_valid;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic [WIDTH-1:0] in_data2;
  logic [WIDTH-1:0] in_data3;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic             out_ready;
  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_mux_4_1.sv
// rr_mux_4_1: round-robin 4:1 mux capturing the granted channel into a one-entry output register
module rr_mux_4_1 #(
  parameter int WIDTH = 4
) (
  input logic         clk,
  input logic         rst,
  rr_mux_4_1_if.slave bus
);
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic [1:0]       last_grant_q, last_grant_d;
  logic             load;
  logic             grant_any;
  logic [1:0]       grant_idx;
  logic [WIDTH-1:0] sel_data;
  assign load = !out_valid_q || bus.out_ready;
  // Rotating-priority search starting just after the last granted channel
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!grant_any && bus.in_valid[2'(last_grant_q + 2'(k + 1))]) begin
        grant_any = 1'b1;
        grant_idx = last_grant_q + 2'(k + 1);
      end
    end
  end
  // Data mux driven by the arbiter's select
  always_comb begin
    sel_data = grant_idx == 2'd0 ? bus.in_data0 :
               grant_idx == 2'd1 ? bus.in_data1 :
               grant_idx == 2'd2 ? bus.in_data2 : bus.in_data3;
  end
  assign bus.in_ready  = (load && grant_any && !rst) ? 4'b0001 << grant_idx : 4'b0000;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  // Refill on load: take the granted item, or go empty while keeping the old payload
  always_comb begin
    out_valid_d  = load ? grant_any : out_valid_q;
    out_data_d   = (load && grant_any) ? sel_data : out_data_q;
    out_sel_d    = (load && grant_any) ? grant_idx : out_sel_q;
    last_grant_d = (load && grant_any) ? grant_idx : last_grant_q;
  end
  // Output register and priority pointer; reset leaves channel 0 first in line
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= 2'd0;
      last_grant_q <= 2'd3;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
    end
  end
endmodule
